// File: rtl/sram_wordline_sequencer.sv
// Clocked, banked SRAM wordline sequencer: precharge -> wordline -> sense/write -> recover.
// Selects are registered and only ever asserted while every bank's precharge is off.
module sram_wordline_sequencer #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned NUM_ROWS   = 64,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_WIDTH = $clog2(NUM_BANKS),
  parameter int unsigned PRE_CYCLES = 2,
  parameter int unsigned WL_CYCLES  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BANK_WIDTH-1:0] req_bank,
  input  logic                  req_we,
  output logic [NUM_BANKS-1:0]  precharge_en,
  output logic [NUM_ROWS-1:0]   row_select,
  output logic [NUM_BANKS-1:0]  bank_select,
  output logic                  write_drive,
  output logic                  sense_en,
  output logic                  done,
  output logic                  range_err
);

  localparam int unsigned MaxPhase = (PRE_CYCLES > WL_CYCLES) ? PRE_CYCLES : WL_CYCLES;
  localparam int unsigned CntWidth = $clog2(MaxPhase) + 1;

  typedef enum logic [2:0] {StIdle, StPre, StWl, StAccess, StRecover} state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BANK_WIDTH-1:0] bank_q;
  logic                  we_q;

  logic                  addr_ok;
  logic                  bank_ok;
  logic [NUM_ROWS-1:0]   row_dec;
  logic [NUM_BANKS-1:0]  bank_dec;

  // Decode from the captured request only, so no output path depends on live inputs.
  always_comb begin
    addr_ok  = (32'(addr_q) < NUM_ROWS);
    bank_ok  = (32'(bank_q) < NUM_BANKS);
    row_dec  = '0;
    bank_dec = '0;
    for (int i = 0; i < NUM_ROWS; i++) begin
      row_dec[i] = addr_ok && bank_ok && (32'(addr_q) == i);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_dec[b] = bank_ok && (32'(bank_q) == b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      bank_q       <= '0;
      we_q         <= 1'b0;
      req_ready    <= 1'b1;
      precharge_en <= '1;
      row_select   <= '0;
      bank_select  <= '0;
      write_drive  <= 1'b0;
      sense_en     <= 1'b0;
      done         <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      done      <= 1'b0;
      range_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            bank_q    <= req_bank;
            we_q      <= req_we;
            cnt_q     <= CntWidth'(PRE_CYCLES - 1);
            req_ready <= 1'b0;
            state_q   <= StPre;
          end
        end
        StPre: begin
          if (cnt_q == '0) begin
            cnt_q        <= CntWidth'(WL_CYCLES - 1);
            precharge_en <= '0;
            row_select   <= row_dec;
            bank_select  <= bank_dec;
            write_drive  <= we_q;
            state_q      <= StWl;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWl: begin
          if (cnt_q == '0) begin
            sense_en <= ~we_q;
            state_q  <= StAccess;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StAccess: begin
          row_select   <= '0;
          bank_select  <= '0;
          write_drive  <= 1'b0;
          sense_en     <= 1'b0;
          precharge_en <= '1;
          done         <= 1'b1;
          range_err    <= ~(addr_ok && bank_ok);
          state_q      <= StRecover;
        end
        StRecover: begin
          req_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_wordline_sequencer.sv
// Randomised self-checking bench for sram_wordline_sequencer; two instances share the request
// inputs, one with the default row count and one with 48 rows for out-of-range addressing.
module tb_sram_wordline_sequencer;

  localparam int PRE    = 2;
  localparam int WL     = 3;
  localparam int ACC_K  = PRE + WL;   // sample offset of the access cycle
  localparam int DONE_K = ACC_K + 1;  // sample offset of the done cycle
  localparam int IDLE_K = DONE_K + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [5:0] req_addr;
  logic [0:0] req_bank;
  logic       req_we;

  logic        rdy_a, wd_a, se_a, done_a, re_a;
  logic [1:0]  pc_a, bs_a;
  logic [63:0] rs_a;
  logic        rdy_b, wd_b, se_b, done_b, re_b;
  logic [1:0]  pc_b, bs_b;
  logic [47:0] rs_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_wordline_sequencer u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_addr(req_addr),
    .req_bank(req_bank), .req_we(req_we), .precharge_en(pc_a), .row_select(rs_a),
    .bank_select(bs_a), .write_drive(wd_a), .sense_en(se_a), .done(done_a), .range_err(re_a)
  );

  sram_wordline_sequencer #(.NUM_ROWS(48)) u_dut48 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_addr(req_addr),
    .req_bank(req_bank), .req_we(req_we), .precharge_en(pc_b), .row_select(rs_b),
    .bank_select(bs_b), .write_drive(wd_b), .sense_en(se_b), .done(done_b), .range_err(re_b)
  );

  // Expected outputs k samples after the transfer edge, from the phase lengths alone.
  // Packing: {precharge, bank_sel, row_sel[63:0], write_drive, sense, done, ready, range_err}.
  function automatic logic [72:0] model(int k, int addr, int bank, bit we, int rows);
    logic [1:0]  pc, bs;
    logic [63:0] rs;
    logic        wd, se, dn, rdy, re;
    pc = 2'b11; bs = '0; rs = '0; wd = 0; se = 0; dn = 0; rdy = 0; re = 0;
    if (k >= PRE && k <= ACC_K) begin
      pc = 2'b00;
      bs = 2'b01 << bank;
      if (addr < rows) rs = 64'd1 << addr;
      wd = we;
      se = (k == ACC_K) && !we;
    end else if (k == DONE_K) begin
      dn = 1'b1;
      re = (addr >= rows);
    end else if (k > DONE_K) begin
      rdy = 1'b1;
    end
    return {pc, bs, rs, wd, se, dn, rdy, re};
  endfunction

  function automatic logic [72:0] act_a();
    return {pc_a, bs_a, rs_a, wd_a, se_a, done_a, rdy_a, re_a & done_a};
  endfunction

  function automatic logic [72:0] act_b();
    return {pc_b, bs_b, 16'h0, rs_b, wd_b, se_b, done_b, rdy_b, re_b & done_b};
  endfunction

  // One transaction from the idle state, checked every cycle on both instances.
  task automatic run_access(input string name, input int addr, input int bank, input bit we,
                            input bit hold, input int next_addr);
    int waited = 0;
    while (rdy_a !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (rdy_a !== 1'b1) begin
      tests++; fails++;
      $display("FAIL %s ready-timeout: req_ready=%b required 1", name, rdy_a);
      return;
    end
    req_valid = 1'b1;
    req_addr  = 6'(addr);
    req_bank  = 1'(bank);
    req_we    = we;
    @(posedge clk); #1;
    req_addr  = 6'(next_addr);
    req_bank  = ~req_bank;
    req_we    = ~we;
    req_valid = hold;
    for (int k = 0; k <= IDLE_K; k++) begin
      logic [72:0] exp_a, exp_b;
      exp_a = model(k, addr, bank, we, 64);
      exp_b = model(k, addr, bank, we, 48);
      tests++;
      if (act_a() !== exp_a) begin
        fails++;
        $display("FAIL %s k=%0d rows64: got %h required %h", name, k, act_a(), exp_a);
      end
      tests++;
      if (act_b() !== exp_b) begin
        fails++;
        $display("FAIL %s k=%0d rows48: got %h required %h", name, k, act_b(), exp_b);
      end
      tests++;
      if ((rs_a != '0 || bs_a != '0) && pc_a != '0) begin
        fails++;
        $display("FAIL %s overlap k=%0d: row=%h bank=%b precharge=%b required no overlap",
                 name, k, rs_a, bs_a, pc_a);
      end
      if (k < IDLE_K) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      tests++;
      if (act_a() !== model(100, 0, 0, 0, 64) || act_b() !== model(100, 0, 0, 0, 48)) begin
        fails++;
        $display("FAIL %s cycle=%0d: got %h / %h required %h", name, c, act_a(), act_b(),
                 model(100, 0, 0, 0, 64));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_bank = '0; req_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset_hold", 1);
    rst = 1'b0;
    check_idle("reset_idle", 20);
  endtask

  task automatic test_single_read();
    run_access("single_read", 5, 1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_write_boundary();
    run_access("write_row0", 0, 0, 1'b1, 1'b0, 0);
    run_access("write_row63", 63, 1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_out_of_range();
    run_access("oor_addr50", 50, 0, 1'b0, 1'b0, 0);
    run_access("oor_addr48_wr", 48, 1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_access("b2b_first", 3, 0, 1'b0, 1'b1, 9);
    run_access("b2b_second", 9, 1, 1'b1, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int gap;
      run_access("random", int'($urandom_range(0, 63)), int'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(0, 63)));
      gap = int'($urandom_range(0, 3));
      if (gap > 0) check_idle("random_gap", gap);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_addr = 6'd17; req_bank = 1'b1; req_we = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (PRE + 1) @(posedge clk);
    #1;
    tests++;
    if (rs_a !== 64'd1 << 17) begin
      fails++;
      $display("FAIL reset_mid_wl: row_select=%h required %h", rs_a, 64'd1 << 17);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("reset_mid_after", 12);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_boundary();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
